// File: rtl/gray_pkg.sv
// gray_pkg: binary/Gray conversion helpers shared by the encoder and the downstream decoders.
// Narrower values are zero-extended to GRAY_W bits, and results are truncated back at the call site.
package gray_pkg;
    localparam int GRAY_W = 64;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] x);
        logic [GRAY_W-1:0] r;
        r[GRAY_W-1] = x[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) r[i] = r[i+1] ^ x[i];
        return r;
    endfunction
endpackage

// File: rtl/bin_gray.sv
// bin_gray: combinational WIDTH-bit binary-to-Gray encoder.
module bin_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = WIDTH'(bin2gray(GRAY_W'(bin)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered, glitch-free Gray image and a wrap pulse.
// g is loaded from the encoded next count, so it is never decoded combinationally from b.
module gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] INIT_G = WIDTH'(bin2gray(GRAY_W'(INIT)));

    logic [WIDTH-1:0] b_q, b_d, g_q, g_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        b_d    = load ? load_bin : en ? (up ? b_q + 1'b1 : b_q - 1'b1) : b_q;
        wrap_d = !load && en && (up ? &b_q : ~|b_q);
    end

    bin_gray #(.WIDTH(WIDTH)) u_enc (
        .bin  (b_d),
        .gray (g_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= INIT;
            g_q    <= INIT_G;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign b    = b_q;
    assign g    = g_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed vectors for gray_counter (WIDTH=3, INIT=0) plus a randomized model-checked run.
module tb_gray_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [2:0] load_bin = '0;
    logic [2:0] b, g;
    logic       wrap;
    int         n_vec = 0, n_err = 0;

    gray_counter #(.WIDTH(3), .INIT(3'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .b        (b),
        .g        (g),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] up_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        logic [2:0] b_m, g_prev;
        logic       w_m, was_step;

        // async reset before any clock edge has been seen
        #3 rst_n = 1'b0;
        #1;
        check("rst_b", b, 0);
        check("rst_g", g, 0);
        check("rst_wrap", wrap, 0);
        @(negedge clk) rst_n = 1'b1;

        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("up_g%0d", i), g, up_g[i]);
            check($sformatf("up_b%0d", i), b, (i + 1) % 8);
            check($sformatf("up_wrap%0d", i), wrap, i == 7);
        end

        up = 1'b0;
        step();
        check("dn_b7", b, 7);
        check("dn_g7", g, 3'b100);
        check("dn_wrap7", wrap, 1);
        step();
        check("dn_b6", b, 6);
        check("dn_g6", g, 3'b101);
        check("dn_wrap6", wrap, 0);

        en = 1'b0;
        step();
        check("hold_b", b, 6);
        check("hold_g", g, 3'b101);

        load = 1'b1; load_bin = 3'd5; en = 1'b1; up = 1'b1;
        step();
        check("ld_b", b, 5);
        check("ld_g", g, 3'b111);
        check("ld_wrap", wrap, 0);
        load = 1'b0;
        step();
        check("ld_nx_b", b, 6);
        check("ld_nx_g", g, 3'b101);

        up = 1'b0;
        step();
        step();
        check("mid_b4", b, 4);
        check("mid_g4", g, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_b", b, 0);
        check("mid_rst_g", g, 0);
        step();
        check("mid_hold_b", b, 0);
        @(negedge clk) rst_n = 1'b1;
        up = 1'b1;
        step();
        check("mid_rel_b", b, 1);
        check("mid_rel_g", g, 3'b001);

        b_m = b;
        for (int c = 0; c < 10000; c++) begin
            load     = ($urandom_range(7) == 0);
            en       = ($urandom_range(3) != 0);
            up       = $urandom_range(1);
            load_bin = 3'($urandom_range(7));
            g_prev   = g;
            was_step = en && !load;
            w_m      = was_step && (up ? b_m == 3'd7 : b_m == 3'd0);
            b_m      = load ? load_bin : !en ? b_m : up ? b_m + 3'd1 : b_m - 3'd1;
            step();
            check("rnd_b", b, b_m);
            check("rnd_dec", 3'(gray2bin(64'(g))), b_m);
            check("rnd_g", g, b_m ^ (b_m >> 1));
            check("rnd_wrap", wrap, w_m);
            if (was_step) check("rnd_ham", $countones(g ^ g_prev), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
